rr_grant_sequencer: RTL and testbench

Eight-requester round-robin arbiter that produces a registered 3-bit grant index plus valid flag. It sits directly upstream of `three_eight_decoder`: `gnt_idx` drives the decoder input, and the decoder's one-hot output gated by `gnt_valid` forms the per-channel grant. It provides fair sharing of a single resource among eight clients, with an optional hold timeout.

---
 rtl/rr_grant_sequencer_pkg.sv | 14 +
 rtl/rr_grant_sequencer_pick8.sv | 40 ++++
 rtl/three_eight_decoder.sv | 11 +
 rtl/rr_grant_sequencer.sv | 87 ++++++++
 tb/tb_rr_grant_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer.
//   NREQ     : number of requesters
//   IDX_W    : width of a requester index
//   ST_IDLE  : FSM state, no grant outstanding
//   ST_GRANT : FSM state, a grant is held by gnt_idx
package rr_grant_sequencer_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_grant_sequencer_pick8.sv
// Combinational round-robin pick for eight requesters.
//   req : input  request vector
//   ptr : input  highest-priority index
//   idx : output first requester at or after ptr (mod NREQ)
//   any : output at least one request is set
module rr_pick8
    import rr_grant_sequencer_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [NREQ-1:0]  rot;
    logic [IDX_W-1:0] off;

    // Rotate right by ptr so that bit 0 of rot is the highest-priority client;
    // the 3-bit index sum wraps naturally modulo 8.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = off + ptr;

endmodule

// File: rtl/three_eight_decoder.sv
// Downstream 3-to-8 one-hot decoder fed by gnt_idx.
//   sel : input  [2:0] binary index
//   dec : output [7:0] one-hot, bit sel set
module three_eight_decoder (
    input  logic [2:0] sel,
    output logic [7:0] dec
);

    assign dec = 8'b0000_0001 << sel;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Eight-requester round-robin arbiter with registered grant index/valid and
// an optional hold timeout.
//   clk       : input  clock, rising edge
//   rst_n     : input  synchronous active-low reset
//   req       : input  request vector, bit i = client i
//   done      : input  owner releases the grant
//   gnt_idx   : output registered granted index (held while gnt_valid=0)
//   gnt_valid : output gnt_idx is a live grant
//   timeout   : output one-cycle pulse on a MAX_HOLD forced release
module rr_grant_sequencer
    import rr_grant_sequencer_pkg::*;
#(
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             own;
    logic             hold_hit;
    logic             rel;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // cnt counts grant cycles already completed, so reaching MAX_HOLD-1
    // means the current cycle is the last one allowed.
    assign own      = req[gnt_idx];
    assign hold_hit = HOLD_EN && (cnt == HOLD_LAST);
    assign rel      = done || !own || hold_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (rel) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        state     <= ST_IDLE;
                        // Only a pure hold expiry counts as a timeout; an
                        // owner that let go on the same cycle did not.
                        timeout   <= hold_hit && !done && own;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
module tb_rr_grant_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic [2:0] a_idx, b_idx;
    logic       a_vld, b_vld, a_to, b_to;
    logic [7:0] a_dec, b_dec;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  checking = 1'b0;

    always #5 clk = ~clk;

    // A: unlimited hold, B: MAX_HOLD = 4
    rr_grant_sequencer #(.MAX_HOLD(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_idx(a_idx), .gnt_valid(a_vld), .timeout(a_to)
    );
    rr_grant_sequencer #(.MAX_HOLD(4), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_idx(b_idx), .gnt_valid(b_vld), .timeout(b_to)
    );
    three_eight_decoder d_a (.sel(a_idx), .dec(a_dec));
    three_eight_decoder d_b (.sel(b_idx), .dec(b_dec));

    // Behavioural model: tracks owner, priority pointer and how many cycles
    // the current grant has been visible.
    typedef struct {
        bit grant;
        int ptr;
        int idx;
        int held;
        bit vld;
        bit to;
    } mstate_t;

    mstate_t m_a, m_b;

    function automatic mstate_t step(mstate_t s, int mh, logic rstn, logic [7:0] r, logic d);
        mstate_t n;
        bit found;
        bit hit;
        n = s;
        if (!rstn) begin
            n.grant = 0; n.ptr = 0; n.idx = 0; n.held = 0; n.vld = 0; n.to = 0;
            return n;
        end
        n.to = 0;
        if (!s.grant) begin
            if (r != 8'h00) begin
                found = 0;
                for (int j = 0; j < 8; j++) begin
                    if (!found && r[(s.ptr + j) % 8]) begin
                        found = 1;
                        n.idx = (s.ptr + j) % 8;
                    end
                end
                n.grant = 1; n.vld = 1; n.held = 1;
            end
        end else begin
            hit = (mh != 0) && (s.held == mh);
            if (d || !r[s.idx] || hit) begin
                n.to    = hit && !d && r[s.idx];
                n.grant = 0;
                n.vld   = 0;
                n.ptr   = (s.idx + 1) % 8;
            end else begin
                n.held = s.held + 1;
            end
        end
        return n;
    endfunction

    initial begin
        m_a = '{default: 0};
        m_b = '{default: 0};
    end

    always @(posedge clk) begin
        m_a <= step(m_a, 0, rst_n, req, done);
        m_b <= step(m_b, 4, rst_n, req, done);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("a_vld", int'(a_vld), int'(m_a.vld));
            chk("a_idx", int'(a_idx), m_a.idx);
            chk("a_to",  int'(a_to),  int'(m_a.to));
            chk("a_dec", int'(a_dec & {8{a_vld}}), m_a.vld ? (1 << m_a.idx) : 0);
            chk("b_vld", int'(b_vld), int'(m_b.vld));
            chk("b_idx", int'(b_idx), m_b.idx);
            chk("b_to",  int'(b_to),  int'(m_b.to));
            chk("b_dec", int'(b_dec & {8{b_vld}}), m_b.vld ? (1 << m_b.idx) : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat_v;
        logic [9:0] pat_t;
        pat_v = 10'b0111101111;
        pat_t = 10'b1000010000;

        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        tick();
        checking = 1'b1;
        tick();

        // Idle after reset
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_vld", int'(a_vld), 0);
            chk("t1_idx", int'(a_idx), 0);
            chk("t1_to",  int'(a_to),  0);
        end

        // Full rotation with done one cycle after each grant
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            chk("t2_vld", int'(a_vld), 1);
            chk("t2_idx", int'(a_idx), g % 8);
            chk("t2_dec", int'(a_dec), 1 << (g % 8));
            done = 1'b1;
            tick();
            chk("t2_bubble", int'(a_vld), 0);
            done = 1'b0;
        end

        // Wrap-around priority: grant 5, then ptr=6 picks 0 before 2
        req = 8'h20;
        tick();
        chk("t3_g5", int'(a_idx), 5);
        req = 8'b0000_0101;
        tick();
        chk("t3_rel_vld", int'(a_vld), 0);
        chk("t3_rel_to",  int'(a_to),  0);
        tick();
        chk("t3_g0", int'(a_idx), 0);
        chk("t3_g0_vld", int'(a_vld), 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t3_g2", int'(a_idx), 2);
        req = 8'h00;
        tick();

        // Grant 2, drop req[2]: release without timeout, ptr moves to 3
        req = 8'h04;
        tick();
        chk("t5_g2", int'(a_idx), 2);
        req = 8'h00;
        tick();
        chk("t5_vld", int'(a_vld), 0);
        chk("t5_to",  int'(b_to),  0);
        req = 8'hFF;
        tick();
        chk("t5_ptr3", int'(a_idx), 3);
        req = 8'h00;
        tick();

        // Hold timeout on B (MAX_HOLD=4); A holds indefinitely
        req = 8'h08;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk("t4_b_vld", int'(b_vld), int'(pat_v[t-1]));
            chk("t4_b_to",  int'(b_to),  int'(pat_t[t-1]));
            if (b_vld) chk("t4_b_idx", int'(b_idx), 3);
            chk("t4_a_vld", int'(a_vld), 1);
            chk("t4_a_to",  int'(a_to),  0);
        end
        req = 8'h00;
        tick();

        // done coincident with the last allowed cycle: no timeout
        req = 8'h08;
        tick();
        tick();
        tick();
        tick();
        chk("t7_b_vld", int'(b_vld), 1);
        done = 1'b1;
        tick();
        chk("t7_b_rel", int'(b_vld), 0);
        chk("t7_b_to",  int'(b_to),  0);
        done = 1'b0;
        req = 8'h00;
        tick();

        // Reset mid-grant, then only client 7 requests
        req = 8'hFF;
        tick();
        chk("t6_g", int'(a_vld), 1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_vld", int'(a_vld), 0);
        chk("t6_rst_idx", int'(a_idx), 0);
        chk("t6_rst_to",  int'(b_to),  0);
        rst_n = 1'b1;
        req = 8'h80;
        tick();
        chk("t6_g7", int'(a_idx), 7);
        chk("t6_g7_b", int'(b_idx), 7);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h00;
        tick();
        tick();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
